fifo_serial_reader: RTL

- Consumer end of the 12-bit decimator output FIFO.
- Pops one word at a time using the FIFO's rd/empty/data_out handshake, then shifts it off-chip MSB-first on a framed serial link (ser_clk/ser_data/ser_frame).
- Sits between the FIFO and the chip pads; it is the only reader of the FIFO.

---
 rtl/iadc_readout_pkg.sv | 25 ++
 rtl/fifo_serial_reader_if.sv | 41 ++++
 rtl/fifo_serial_reader_ser_bit_timer.sv | 56 +++++
 rtl/fifo_serial_reader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/iadc_readout_pkg.sv
// rtl/iadc_readout_pkg.sv - shared state encoding, widths and frame sizing for the ADC readout path
// Contents:
//   DATA_W_DEF  default FIFO word width
//   WORDS_W     width of the completed-word counter
//   rd_state_t  reader FSM state encoding (IDLE=0, REQ=1, WAIT=2, SHIFT=3, GAP=4)
//   frame_bits  number of bit periods in one serial frame
package iadc_readout_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int WORDS_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } rd_state_t;

    // The parity bit, when present, occupies one extra bit period after bit 0.
    function automatic int frame_bits(input int data_w, input bit parity_en);
        return data_w + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/fifo_serial_reader_if.sv
// rtl/fifo_serial_reader_if.sv - FIFO read handshake plus framed serial link bundle
// Signals:
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after the FIFO samples fifo_rd
//   fifo_rd     one-cycle pop request to the FIFO
//   ser_clk     serial bit clock
//   ser_data    serial data, MSB first
//   ser_frame   high while a word is on the link
// Modports:
//   master  the reader (pops the FIFO, drives the link)
//   slave   the FIFO / pad side
interface fifo_serial_reader_if #(
    parameter int DATA_W = 12
) ();

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              ser_clk;
    logic              ser_data;
    logic              ser_frame;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output ser_clk,
        output ser_data,
        output ser_frame
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  ser_clk,
        input  ser_data,
        input  ser_frame
    );

endinterface

// File: rtl/fifo_serial_reader_ser_bit_timer.sv
// rtl/fifo_serial_reader_ser_bit_timer.sv - CLK_DIV bit-period divider and serial clock generator
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   active     high while the reader is in SHIFT; divider held clear otherwise
//   bit_start  strobe on the first clock of every bit period
//   bit_end    strobe on the last clock of every bit period
//   ser_clk    serial clock level: low for the first half of a bit, high for the second
module ser_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic bit_start,
    output logic bit_end,
    output logic ser_clk
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic             half_point;
    logic             ser_clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_start  = active && (cnt == '0);
    assign half_point = active && (cnt == CNT_HALF);
    assign bit_end    = active && (cnt == CNT_LAST);

    // ser_clk is a flop so the pad sees a clean edge: it rises on the clock
    // after the last low-half cycle and falls together with the next bit start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_clk_q <= 1'b0;
        end else if (!active || bit_end) begin
            ser_clk_q <= 1'b0;
        end else if (half_point) begin
            ser_clk_q <= 1'b1;
        end
    end

    assign ser_clk = ser_clk_q;

endmodule

// File: rtl/fifo_serial_reader.sv
// rtl/fifo_serial_reader.sv - pops decimator FIFO words and shifts them off-chip MSB-first on a framed link
// Configuration macro: FIFO_SERIAL_PARITY_EN appends an even-parity bit period after bit 0.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          readout enable, checked only in IDLE
//   bus         fifo_serial_reader_if.master: fifo_empty/fifo_data/fifo_rd, ser_clk/ser_data/ser_frame
//   busy        high in any state other than IDLE
//   words_sent  count of completed words, wraps at 0xFFFF
module fifo_serial_reader
    import iadc_readout_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    fifo_serial_reader_if.master bus,
    output logic                 busy,
    output logic [WORDS_W-1:0]   words_sent
);

`ifdef FIFO_SERIAL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int BITS = frame_bits(DATA_W, PARITY_EN);
    localparam int BC_W = $clog2(BITS + 1);
    localparam int GC_W = $clog2(GAP_CYC + 1);

    rd_state_t        state;
    rd_state_t        state_n;
    logic [BITS-1:0]  sreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [GC_W-1:0]  gap_cnt;
    logic             shift_active;
    logic             bit_start;
    logic             bit_end;
    logic             word_done;
    logic             fifo_rd_q;
    logic             frame_q;
    logic             busy_q;

    assign shift_active = (state == ST_SHIFT);

    ser_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (shift_active),
        .bit_start (bit_start),
        .bit_end   (bit_end),
        .ser_clk   (bus.ser_clk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        word_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en && !bus.fifo_empty) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                // bit_cnt already counts the current bit, so it equals BITS
                // during the final bit period.
                if (bit_end && bit_cnt == BC_W'(BITS)) begin
                    state_n   = ST_GAP;
                    word_done = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GC_W'(GAP_CYC - 1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pad-facing strobes are registered from the next state so they carry
    // no decode glitches and still line up exactly with the state they mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            fifo_rd_q <= (state_n == ST_REQ);
            frame_q   <= (state_n == ST_SHIFT);
            busy_q    <= (state_n != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (state == ST_WAIT) begin
`ifdef FIFO_SERIAL_PARITY_EN
            sreg <= {bus.fifo_data, ^bus.fifo_data};
`else
            sreg <= bus.fifo_data;
`endif
        end else if (bit_end) begin
            sreg <= {sreg[BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (!shift_active) begin
            bit_cnt <= '0;
        end else if (bit_start) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state != ST_GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_sent <= '0;
        end else if (word_done) begin
            words_sent <= words_sent + 1'b1;
        end
    end

    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.ser_frame = frame_q;
    assign bus.ser_data  = frame_q & sreg[BITS-1];
    assign busy          = busy_q;

endmodule
